// File: rtl/io_led_switch_ctrl.sv
// Memory-mapped LED output register and debounced switch input register.
// Define SW_DEBOUNCE_EN to compile in the DB_CYCLES stability filter on the switches.
module io_led_switch_ctrl #(
    parameter logic [31:0] LED_ADDR  = 32'hFFFF_FC60,
    parameter logic [31:0] SW_ADDR   = 32'hFFFF_FC70,
    parameter logic [19:0] DB_CYCLES = 20'd1000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        led_ctrl,
    input  logic        switch_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic [15:0] switch_in,
    output logic [15:0] io_read_data,
    output logic [15:0] led,
    output logic        sw_changed
);

    logic [15:0] s1;
    logic [15:0] s2;
    logic [15:0] sw_stable;
    logic [15:0] sw_stable_d;
    logic        sw_changed_d;

    logic [15:0] unused_write_data;
    assign unused_write_data = write_data[31:16];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led <= 16'h0000;
        end else if (led_ctrl && (addr == LED_ADDR)) begin
            led <= write_data[15:0];
        end
    end

    // Raw switches are asynchronous to clock; two flops before any use.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1 <= 16'h0000;
            s2 <= 16'h0000;
        end else begin
            s1 <= switch_in;
            s2 <= s1;
        end
    end

`ifdef SW_DEBOUNCE_EN
    logic [19:0] db_cnt;
    logic [19:0] db_cnt_d;

    // Count consecutive edges on which s2 differs from sw_stable as a whole vector;
    // only a return to sw_stable restarts the window.
    always_comb begin
        sw_stable_d  = sw_stable;
        db_cnt_d     = db_cnt;
        sw_changed_d = 1'b0;
        if (s2 == sw_stable) begin
            db_cnt_d = 20'd0;
        end else if (db_cnt == (DB_CYCLES - 20'd1)) begin
            sw_stable_d  = s2;
            db_cnt_d     = 20'd0;
            sw_changed_d = 1'b1;
        end else begin
            db_cnt_d = db_cnt + 20'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_cnt <= 20'd0;
        end else begin
            db_cnt <= db_cnt_d;
        end
    end
`else
    logic [19:0] unused_db_cycles;
    assign unused_db_cycles = DB_CYCLES;

    always_comb begin
        sw_stable_d  = s2;
        sw_changed_d = (s2 != sw_stable);
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sw_stable  <= 16'h0000;
            sw_changed <= 1'b0;
        end else begin
            sw_stable  <= sw_stable_d;
            sw_changed <= sw_changed_d;
        end
    end

    assign io_read_data = (switch_ctrl && (addr == SW_ADDR)) ? sw_stable : 16'h0000;

endmodule

// File: tb/tb_io_led_switch_ctrl.sv
// Self-checking bench for io_led_switch_ctrl: vector table, directed corner sequences and
// randomized traffic against a behavioural model. Honours SW_DEBOUNCE_EN like the design.
module tb_io_led_switch_ctrl;

    localparam logic [31:0] LED_A = 32'hFFFF_FC60;
    localparam logic [31:0] SW_A  = 32'hFFFF_FC70;
    localparam int          DB    = 4;
`ifdef SW_DEBOUNCE_EN
    localparam bit          DEB   = 1'b1;
    localparam int          LAT   = 1 + DB;
    localparam logic [15:0] STEP  = 16'h00F0;
`else
    localparam bit          DEB   = 1'b0;
    localparam int          LAT   = 2;
    localparam logic [15:0] STEP  = 16'h0001;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        led_ctrl = 1'b0;
    logic        switch_ctrl = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] write_data = 32'h0;
    logic [15:0] switch_in = 16'h0;
    logic [15:0] io_read_data;
    logic [15:0] led;
    logic        sw_changed;

    int tests = 0;
    int fails = 0;

    io_led_switch_ctrl #(
        .LED_ADDR (LED_A),
        .SW_ADDR  (SW_A),
        .DB_CYCLES(20'(DB))
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .led_ctrl    (led_ctrl),
        .switch_ctrl (switch_ctrl),
        .addr        (addr),
        .write_data  (write_data),
        .switch_in   (switch_in),
        .io_read_data(io_read_data),
        .led         (led),
        .sw_changed  (sw_changed)
    );

    always #5 clock = ~clock;

    // Behavioural model: raw switch values reach the filter two edges late; the filtered value
    // adopts the synchronized value once it has differed on DB consecutive edges.
    logic [15:0] m_led;
    logic [15:0] m_stable;
    logic        m_changed;
    logic [15:0] pipe [2];
    int          m_run;

    task automatic model_reset();
        m_led = 16'h0; m_stable = 16'h0; m_changed = 1'b0;
        pipe[0] = 16'h0; pipe[1] = 16'h0; m_run = 0;
    endtask

    task automatic model_edge();
        logic [15:0] sync;
        if (reset) begin
            model_reset();
        end else begin
            sync = pipe[1];
            if (led_ctrl && addr == LED_A) m_led = write_data[15:0];
            if (DEB) begin
                if (sync == m_stable) m_run = 0;
                else m_run = m_run + 1;
                m_changed = (m_run == DB);
                if (m_changed) begin
                    m_stable = sync;
                    m_run = 0;
                end
            end else begin
                m_changed = (sync != m_stable);
                m_stable = sync;
            end
            pipe[1] = pipe[0];
            pipe[0] = switch_in;
        end
    endtask

    function automatic logic [15:0] m_rd();
        return (switch_ctrl && addr == SW_A) ? m_stable : 16'h0;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " led"}, led, m_led);
        chk({tag, " io_read_data"}, io_read_data, m_rd());
        chk({tag, " sw_changed"}, {15'b0, sw_changed}, {15'b0, m_changed});
    endtask

    typedef struct {
        logic        lc;
        logic        sc;
        logic [31:0] a;
        logic [31:0] wd;
        logic [15:0] exp_led;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [15:0] toggle_raw(input int j);
        if (j < 0) return 16'h0;
        if (j < 2) return 16'h1;
        if (j < 4) return 16'h0;
        return 16'h1;
    endfunction

    initial begin
        logic [15:0] exp;
        vecs[0] = '{1'b1, 1'b0, LED_A,         32'h1234_BEEF, 16'hBEEF};
        vecs[1] = '{1'b1, 1'b0, 32'hFFFF_FC64, 32'h0000_0000, 16'hBEEF};
        vecs[2] = '{1'b0, 1'b0, LED_A,         32'h0000_FFFF, 16'hBEEF};
        vecs[3] = '{1'b1, 1'b0, SW_A,          32'h0000_1111, 16'hBEEF};
        vecs[4] = '{1'b1, 1'b1, LED_A,         32'h0000_5A5A, 16'h5A5A};
        vecs[5] = '{1'b1, 1'b0, 32'h7FFF_FC60, 32'h0000_FFFF, 16'h5A5A};
        vecs[6] = '{1'b1, 1'b0, LED_A,         32'hFFFF_0000, 16'h0000};
        vecs[7] = '{1'b1, 1'b0, LED_A,         32'h0000_A5A5, 16'hA5A5};

        model_reset();
        #12;
        switch_ctrl = 1'b1; addr = SW_A;
        #1;
        chk("reset led", led, 16'h0);
        chk("reset io_read_data", io_read_data, 16'h0);
        chk("reset sw_changed", {15'b0, sw_changed}, 16'h0);
        reset = 1'b0;
        switch_ctrl = 1'b0;

        // LED address decode vectors
        for (int i = 0; i < 8; i++) begin
            led_ctrl = vecs[i].lc; switch_ctrl = vecs[i].sc;
            addr = vecs[i].a; write_data = vecs[i].wd;
            tick();
            chk($sformatf("vec%0d led", i), led, vecs[i].exp_led);
            chk($sformatf("vec%0d io_read_data", i), io_read_data, 16'h0);
        end

        // Asynchronous reset mid-cycle with LED lit
        led_ctrl = 1'b0; switch_ctrl = 1'b1; addr = SW_A;
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async reset led", led, 16'h0);
        chk("async reset io_read_data", io_read_data, 16'h0);
        chk("async reset sw_changed", {15'b0, sw_changed}, 16'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // Held switch step
        switch_in = STEP;
        for (int j = 0; j <= LAT + 1; j++) begin
            tick();
            exp = (j >= LAT) ? STEP : 16'h0;
            chk($sformatf("step edge%0d io_read_data", j), io_read_data, exp);
            chk($sformatf("step edge%0d sw_changed", j), {15'b0, sw_changed},
                {15'b0, (j == LAT)});
        end

        reset = 1'b1; switch_in = 16'h0;
        tick();
        reset = 1'b0;
        tick();
        tick();

        // Bouncing switch 0->1->0->1, two edges per level
        for (int j = 0; j <= 4 + LAT + 1; j++) begin
            switch_in = toggle_raw(j);
            tick();
            if (DEB) exp = (j >= 4 + LAT) ? 16'h1 : 16'h0;
            else exp = toggle_raw(j - 2);
            chk($sformatf("bounce edge%0d io_read_data", j), io_read_data, exp);
            check_model($sformatf("bounce edge%0d", j));
        end

        // Read strobe with the LED address returns zero
        switch_ctrl = 1'b1; addr = SW_A;
        #1;
        chk("sw read nonzero", io_read_data, 16'h1);
        addr = LED_A;
        #1;
        chk("sw read wrong addr", io_read_data, 16'h0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 149) == 0);
            led_ctrl = 1'($urandom_range(0, 1));
            switch_ctrl = 1'($urandom_range(0, 1));
            write_data = $urandom;
            case ($urandom_range(0, 3))
                0: addr = LED_A;
                1: addr = SW_A;
                2: addr = LED_A + 32'd4;
                default: addr = $urandom;
            endcase
            case ($urandom_range(0, 11))
                0: switch_in = 16'h0000;
                1: switch_in = 16'h00F0;
                2: switch_in = 16'h8001;
                3: switch_in = switch_in ^ (16'h1 << $urandom_range(0, 15));
                default: ;
            endcase
            tick();
            check_model($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
